// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program counter (pc_sequencer).
// The optional branch delay slot is enabled by defining PC_DELAY_SLOT_EN.
package pc_pkg;

   typedef enum logic [1:0] {
      BR_BEQ  = 2'b00,
      BR_BNE  = 2'b01,
      BR_BLEZ = 2'b10,
      BR_BGTZ = 2'b11
   } br_type_t;

   typedef enum logic {
      ST_RUN = 1'b0,
      ST_EXC = 1'b1
   } pc_state_t;

   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

   function automatic logic branch_taken(input br_type_t bt, input logic zero, input logic neg);
      logic taken;
      case (bt)
         BR_BEQ:  taken = zero;
         BR_BNE:  taken = !zero;
         BR_BLEZ: taken = zero | neg;
         BR_BGTZ: taken = !zero & !neg;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/pc_target_gen.sv
// Combinational next-address candidates for pc_sequencer: pc+4, branch and jump
// targets, and the branch-taken decode.
module pc_target_gen
   import pc_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [15:0]       field_addr16,
   input  logic [25:0]       field_addr26,
   input  logic [1:0]        branch_type,
   input  logic              zero_flag,
   input  logic              neg_flag,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic [ADDR_W-1:0] branch_tgt,
   output logic [ADDR_W-1:0] jump_tgt,
   output logic              br_taken
);

   logic [ADDR_W-1:0] br_offset;

   assign pc_plus4   = pc + ADDR_W'(4);
   assign br_offset  = {{(ADDR_W-18){field_addr16[15]}}, field_addr16, 2'b00};
   assign branch_tgt = pc_plus4 + br_offset;
   assign jump_tgt   = {pc_plus4[ADDR_W-1:28], field_addr26, 2'b00};
   assign br_taken   = branch_taken(br_type_t'(branch_type), zero_flag, neg_flag);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with branch/jump/JR sequencing and exception entry/return.
// Define PC_DELAY_SLOT_EN to defer taken control transfers by one delay-slot instruction.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int unsigned ADDR_W       = 32,
   parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic [15:0]       field_addr16,
   input  logic [25:0]       field_addr26,
   input  logic [ADDR_W-1:0] rs_data,
   input  logic              jump_en,
   input  logic              jump_reg_en,
   input  logic              branch_en,
   input  logic [1:0]        branch_type,
   input  logic              zero_flag,
   input  logic              neg_flag,
   input  logic              exc_req,
   input  logic              eret,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic [ADDR_W-1:0] link_addr,
   output logic [ADDR_W-1:0] epc,
   output logic              in_exc,
   output logic              redirect,
   output logic              align_err
);

   localparam logic [ADDR_W-1:0] RST_PC = {RESET_VECTOR[ADDR_W-1:2], 2'b00};
   localparam logic [ADDR_W-1:0] EXC_PC = {EXC_VECTOR[ADDR_W-1:2], 2'b00};

   pc_state_t         state;
   logic [ADDR_W-1:0] branch_tgt;
   logic [ADDR_W-1:0] jump_tgt;
   logic              br_taken;
   logic              jr_mis;
   logic              tgt_valid;
   logic [ADDR_W-1:0] tgt;

`ifdef PC_DELAY_SLOT_EN
   logic              pending;
   logic [ADDR_W-1:0] pending_tgt;
`endif

   pc_target_gen #(
      .ADDR_W(ADDR_W)
   ) u_target_gen (
      .pc          (pc),
      .field_addr16(field_addr16),
      .field_addr26(field_addr26),
      .branch_type (branch_type),
      .zero_flag   (zero_flag),
      .neg_flag    (neg_flag),
      .pc_plus4    (pc_plus4),
      .branch_tgt  (branch_tgt),
      .jump_tgt    (jump_tgt),
      .br_taken    (br_taken)
   );

   assign link_addr = pc_plus4;
   assign in_exc    = (state == ST_EXC);
   assign jr_mis    = jump_reg_en && (rs_data[1:0] != 2'b00);

   // A misaligned JR never selects a target here: in RUN it is trapped before this
   // is consulted, in EXC it degrades to plain sequential fetch.
   always_comb begin
      tgt_valid = 1'b0;
      tgt       = pc_plus4;
      if (jump_reg_en) begin
         if (!jr_mis) begin
            tgt_valid = 1'b1;
            tgt       = rs_data;
         end
      end else if (jump_en) begin
         tgt_valid = 1'b1;
         tgt       = jump_tgt;
      end else if (branch_en && br_taken) begin
         tgt_valid = 1'b1;
         tgt       = branch_tgt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc        <= RST_PC;
         epc       <= '0;
         state     <= ST_RUN;
         redirect  <= 1'b0;
         align_err <= 1'b0;
`ifdef PC_DELAY_SLOT_EN
         pending     <= 1'b0;
         pending_tgt <= '0;
`endif
      end else begin
         redirect  <= 1'b0;
         align_err <= 1'b0;
`ifdef PC_DELAY_SLOT_EN
         // The delay-slot instruction is at pc, so a trap while pending returns to its branch.
         if (state == ST_RUN && exc_req) begin
            epc      <= pending ? pc - ADDR_W'(4) : pc;
            pc       <= EXC_PC;
            state    <= ST_EXC;
            redirect <= 1'b1;
            pending  <= 1'b0;
         end else if (pending) begin
            if (!stall) begin
               pc       <= pending_tgt;
               pending  <= 1'b0;
               redirect <= 1'b1;
            end
         end else
`endif
         if (state == ST_RUN && (exc_req || jr_mis)) begin
            epc       <= pc;
            pc        <= EXC_PC;
            state     <= ST_EXC;
            redirect  <= 1'b1;
            align_err <= !exc_req;
         end else if (state == ST_EXC && eret) begin
            pc       <= epc;
            state    <= ST_RUN;
            redirect <= 1'b1;
         end else if (!stall) begin
`ifdef PC_DELAY_SLOT_EN
            pc <= pc_plus4;
            if (tgt_valid) begin
               pending     <= 1'b1;
               pending_tgt <= tgt;
            end
`else
            pc       <= tgt;
            redirect <= tgt_valid;
`endif
         end
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer (default build, delay slot disabled).
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [15:0] field_addr16;
   logic [25:0] field_addr26;
   logic [31:0] rs_data;
   logic        jump_en, jump_reg_en, branch_en;
   logic [1:0]  branch_type;
   logic        zero_flag, neg_flag, exc_req, eret;
   logic [31:0] pc, pc_plus4, link_addr, epc;
   logic        in_exc, redirect, align_err;

   always #5 clk = ~clk;

   pc_sequencer #(
      .ADDR_W      (32),
      .RESET_VECTOR(32'h0040_0000),
      .EXC_VECTOR  (32'h0000_0080)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .field_addr16(field_addr16),
      .field_addr26(field_addr26),
      .rs_data     (rs_data),
      .jump_en     (jump_en),
      .jump_reg_en (jump_reg_en),
      .branch_en   (branch_en),
      .branch_type (branch_type),
      .zero_flag   (zero_flag),
      .neg_flag    (neg_flag),
      .exc_req     (exc_req),
      .eret        (eret),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .link_addr   (link_addr),
      .epc         (epc),
      .in_exc      (in_exc),
      .redirect    (redirect),
      .align_err   (align_err)
   );

   typedef struct {
      logic [31:0] pc;
      logic        redirect;
      logic        align_err;
      logic        in_exc;
      logic [31:0] epc;
   } exp_t;

   exp_t        q[$];
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   localparam logic [31:0] E = 32'h1000_0200;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: actual %h required %h", name, $time, act, req);
      end
   endtask

   // Monitor: one expectation per clock, sampled just after the edge it describes.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc",        pc,                e.pc);
            chk("pc_plus4",  pc_plus4,          e.pc + 32'd4);
            chk("link_addr", link_addr,         e.pc + 32'd4);
            chk("redirect",  {31'b0, redirect}, {31'b0, e.redirect});
            chk("align_err", {31'b0, align_err},{31'b0, e.align_err});
            chk("in_exc",    {31'b0, in_exc},   {31'b0, e.in_exc});
            chk("epc",       epc,               e.epc);
         end
      end
   end

   task automatic idle();
      stall = 0; field_addr16 = '0; field_addr26 = '0; rs_data = '0;
      jump_en = 0; jump_reg_en = 0; branch_en = 0; branch_type = 2'b00;
      zero_flag = 0; neg_flag = 0; exc_req = 0; eret = 0;
   endtask

   task automatic step(input logic [31:0] e_pc, input logic e_red, input logic e_al,
                       input logic e_exc, input logic [31:0] e_epc);
      exp_t e;
      e.pc = e_pc; e.redirect = e_red; e.align_err = e_al; e.in_exc = e_exc; e.epc = e_epc;
      q.push_back(e);
      @(negedge clk);
      idle();
   endtask

   task automatic br(input logic [1:0] t, input logic z, input logic n, input logic [15:0] off);
      branch_en = 1; branch_type = t; zero_flag = z; neg_flag = n; field_addr16 = off;
   endtask

   initial begin
      idle();
      reset = 1;
      @(negedge clk);
      step(32'h0040_0000, 0, 0, 0, 0);
      reset = 1; jump_en = 1; exc_req = 1;
      step(32'h0040_0000, 0, 0, 0, 0);
      reset = 0;
      step(32'h0040_0004, 0, 0, 0, 0);
      step(32'h0040_0008, 0, 0, 0, 0);
      step(32'h0040_000C, 0, 0, 0, 0);
      step(32'h0040_0010, 0, 0, 0, 0);
      br(2'b01, 0, 0, 16'hFFFC);
      step(32'h0040_0004, 1, 0, 0, 0);
      step(32'h0040_0008, 0, 0, 0, 0);
      step(32'h0040_000C, 0, 0, 0, 0);
      step(32'h0040_0010, 0, 0, 0, 0);
      br(2'b01, 1, 0, 16'hFFFC);
      step(32'h0040_0014, 0, 0, 0, 0);
      jump_reg_en = 1; rs_data = 32'h1000_0000;
      step(32'h1000_0000, 1, 0, 0, 0);
      jump_en = 1; field_addr26 = 26'h000_0040;
      step(32'h1000_0100, 1, 0, 0, 0);
      jump_en = 1; field_addr26 = 26'h000_0080; br(2'b00, 1, 0, 16'h0010);
      step(E, 1, 0, 0, 0);
      jump_reg_en = 1; rs_data = 32'h0040_0102;
      step(32'h0000_0080, 1, 1, 1, E);
      exc_req = 1;
      step(32'h0000_0084, 0, 0, 1, E);
      jump_reg_en = 1; rs_data = 32'h0000_0103;
      step(32'h0000_0088, 0, 0, 1, E);
      eret = 1;
      step(E, 1, 0, 0, E);
      for (int i = 0; i < 3; i++) begin
         stall = 1; br(2'b00, 1, 0, 16'h0004);
         step(E, 0, 0, 0, E);
      end
      stall = 1; exc_req = 1;
      step(32'h0000_0080, 1, 0, 1, E);
      eret = 1;
      step(E, 1, 0, 0, E);
      br(2'b00, 1, 0, 16'h0004);
      step(32'h1000_0214, 1, 0, 0, E);
      br(2'b10, 0, 1, 16'h0008);
      step(32'h1000_0238, 1, 0, 0, E);
      br(2'b11, 0, 0, 16'hFFF8);
      step(32'h1000_021C, 1, 0, 0, E);
      br(2'b11, 0, 1, 16'h0008);
      step(32'h1000_0220, 0, 0, 0, E);
      br(2'b00, 0, 0, 16'h0008);
      step(32'h1000_0224, 0, 0, 0, E);
      eret = 1;
      step(32'h1000_0228, 0, 0, 0, E);
      reset = 1;
      step(32'h0040_0000, 0, 0, 0, 0);
      reset = 0;
      step(32'h0040_0004, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #2;
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: actual %0d pending expectations required 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised next-generation program counter for the MIPS core fetch stage. Adds over the earlier PC:
- configurable address width and reset/exception vectors;
- stall hold, four branch conditions and jump-register;
- exception entry/return FSM with EPC capture;
- a redirect pulse that the pipeline uses for flushing.

Sits between the control unit/ALU flags and instruction memory address input.

Parameters:
ADDR_W, 32, PC width in bits; legal range 30..32; upper bits of jump target are pc_plus4[ADDR_W-1:28].
RESET_VECTOR, 32'h0000_0000, PC value after reset (truncated to ADDR_W).
EXC_VECTOR, 32'h0000_0080, PC value on exception entry.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hold PC/state this cycle (exception entry and eret still honoured)
field_addr16  in  16  branch offset (words, signed)
field_addr26  in  26  jump target field
rs_data  in  ADDR_W  jump-register target
jump_en  in  1  J/JAL
jump_reg_en  in  1  JR/JALR
branch_en  in  1  conditional branch
branch_type  in  2  00 BEQ, 01 BNE, 10 BLEZ, 11 BGTZ
zero_flag  in  1  ALU zero
neg_flag  in  1  ALU result negative
exc_req  in  1  exception request
eret  in  1  exception return
pc  out  ADDR_W  current fetch address
pc_plus4  out  ADDR_W  pc + 4, combinational
link_addr  out  ADDR_W  pc + 4 for JAL/JALR writeback, combinational
epc  out  ADDR_W  exception program counter
in_exc  out  1  high while in EXC state
redirect  out  1  registered one-cycle pulse: previous update was non-sequential
align_err  out  1  registered one-cycle pulse: JR target misaligned

Behaviour:
- Reset (reset=1 at clk edge):
  - pc=RESET_VECTOR, epc=0, state=RUN;
  - redirect=0, align_err=0, in_exc=0;
  - delay-slot pending cleared.
  - Reset overrides every other input.
- Arithmetic: all sums are modulo 2^ADDR_W; pc[1:0] always 00.
  - Branch target = pc_plus4 + (sign-extended field_addr16 << 2).
  - Jump target = {pc_plus4[ADDR_W-1:28], field_addr26, 2'b00}.
- Branch taken conditions:
  - BEQ: zero;
  - BNE: !zero;
  - BLEZ: zero | neg;
  - BGTZ: !zero & !neg.
- FSM states: RUN, EXC.
- RUN priority, highest first:
  1. exc_req: epc<=pc, pc<=EXC_VECTOR, state<=EXC, redirect<=1.
  2. jump_reg_en with rs_data[1:0]!=0: treated as exception; epc<=pc, pc<=EXC_VECTOR, state<=EXC, align_err<=1, redirect<=1.
  3. stall: all state held, redirect<=0.
  4. jump_reg_en: pc<=rs_data.
  5. jump_en: pc<=jump target.
  6. branch_en & taken: pc<=branch target.
  7. Otherwise: pc<=pc_plus4.
- Cases 4–6 set redirect<=1; case 7 sets redirect<=0.
- EXC state:
  - exc_req ignored (no nesting);
  - eret: pc<=epc, state<=RUN, redirect<=1;
  - else normal sequencing as RUN cases 3–7;
  - a misaligned JR in EXC is ignored as a jump and pc<=pc_plus4.
- eret in RUN is ignored.
- Simultaneous jump_en and branch_en: jump wins.
- Latency: redirect visible on pc one cycle after the control inputs are sampled.

Optional Feature:
PC_DELAY_SLOT_EN
- Defined: a taken jump/JR/branch latches its target into pending_tgt and sets pending; pc<=pc_plus4 (delay slot executes).
  - On the next non-stalled update, pc<=pending_tgt, pending cleared, redirect<=1.
  - Control inputs arriving while pending are ignored except exc_req.
  - exc_req while pending: epc<=pc-4, pending cleared.
  - stall holds pending.
- Undefined: no pending register; redirect applies on the next edge as above.

Decomposition:
Shared package pc_pkg contains:
- branch_type constants (BR_BEQ, BR_BNE, BR_BLEZ, BR_BGTZ);
- FSM state encodings (ST_RUN, ST_EXC);
- default vector constants.

One natural sub-module, pc_target_gen: combinational pc_plus4, branch target, jump target, taken decode, parametrised by ADDR_W.

Test Plan:
- Reset with RESET_VECTOR=32'h0040_0000 -> pc=0x00400000; 3 free cycles -> pc 0x00400004, 0x00400008, 0x0040000C; redirect=0.
- pc=0x00400010, branch_en, BNE, zero=0, field_addr16=16'hFFFC -> pc=0x00400004, redirect pulses 1 cycle; same case with zero=1 -> pc=0x00400014.
- pc=0x10000000, jump_en, field_addr26=26'h0000040 -> pc=0x10000100; jump_en+branch_en together -> jump target taken.
- jump_reg_en, rs_data=0x00400102 -> pc=0x00000080, align_err=1, epc=old pc, in_exc=1; exc_req again ignored; eret -> pc=epc, in_exc=0.
- stall held 3 cycles during branch_en taken -> pc unchanged; exc_req during stall -> pc=EXC_VECTOR next edge.
- PC_DELAY_SLOT_EN: pc=0x100, taken BEQ offset 4 -> pc 0x104 then 0x114; reset asserted mid-pending -> pc=RESET_VECTOR, pending cleared.
